// File: rtl/com_cmd.sv
// Command sink for the com receive path: validates and decodes one 32-bit
// command word per packet, updates acquisition config, then requests an ACK/NAK reply.
module com_cmd #(
  parameter logic [3:0]  BTYPE_CMD  = 4'h1,
  parameter logic [3:0]  BTYPE_ACK  = 4'h2,
  parameter logic [3:0]  BTYPE_NAK  = 4'h3,
  parameter logic [11:0] REPLY_DLEN = 12'd4,
  parameter logic [11:0] REPLY_ADDR = 12'h000,
  parameter logic [7:0]  RATE_DEF   = 8'd10,
  parameter logic [15:0] MASK_DEF   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_read,
  input  logic [3:0]  read_btype,
  input  logic [31:0] cache_cmd,
  output logic        fd_read,
  output logic        fs_send,
  output logic [3:0]  send_btype,
  output logic [11:0] send_dlen,
  output logic [11:0] ram_addr_init,
  input  logic        fd_send,
  output logic [7:0]  adc_rate,
  output logic [15:0] chan_mask,
  output logic        run,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE, LATCH, CHECK, APPLY, ACK, REPLY, RDONE
  } state_t;

  state_t      state;
  logic [31:0] cmd_q;
  logic [3:0]  btype_q;
  logic        ok_q;

  logic        is_cmd;
  logic [3:0]  opcode;
  logic [15:0] data;
  logic [7:0]  csum;

  assign is_cmd = (btype_q == BTYPE_CMD);
  assign opcode = cmd_q[27:24];
  assign data   = cmd_q[23:8];
  assign csum   = cmd_q[31:24] ^ cmd_q[23:16] ^ cmd_q[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_q         <= '0;
      btype_q       <= '0;
      ok_q          <= 1'b0;
      fd_read       <= 1'b0;
      fs_send       <= 1'b0;
      send_btype    <= '0;
      send_dlen     <= '0;
      ram_addr_init <= '0;
      adc_rate      <= RATE_DEF;
      chan_mask     <= MASK_DEF;
      run           <= 1'b0;
      err_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fs_read) state <= LATCH;
        end
        LATCH: begin
          cmd_q   <= cache_cmd;
          btype_q <= read_btype;
          state   <= CHECK;
        end
        CHECK: begin
          ok_q  <= is_cmd && (cmd_q[31:28] == 4'hA) && (cmd_q[7:0] == csum)
                   && (opcode <= 4'd5);
          state <= APPLY;
        end
        APPLY: begin
          if (ok_q) begin
            case (opcode)
              4'd1: adc_rate  <= data[7:0];
              4'd2: chan_mask <= data;
              4'd3: run       <= 1'b1;
              4'd4: run       <= 1'b0;
              4'd5: begin
                adc_rate  <= RATE_DEF;
                chan_mask <= MASK_DEF;
                run       <= 1'b0;
              end
              default: ;
            endcase
          end else if (is_cmd && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
          fd_read <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          // Reply fields are loaded with fs_send so they stay stable through REPLY/RDONE.
          if (!fs_read) begin
            fd_read <= 1'b0;
            if (is_cmd) begin
              fs_send       <= 1'b1;
              send_btype    <= ok_q ? BTYPE_ACK : BTYPE_NAK;
              send_dlen     <= REPLY_DLEN;
              ram_addr_init <= REPLY_ADDR;
              state         <= REPLY;
            end else begin
              state <= IDLE;
            end
          end
        end
        REPLY: begin
          if (fd_send) begin
            fs_send <= 1'b0;
            state   <= RDONE;
          end
        end
        RDONE: begin
          if (!fd_send) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_com_cmd.sv
// Bench for com_cmd: vector table of commands with expected config/reply,
// reply scoreboard, and hand-written handshake corner cases.
module tb_com_cmd;

  logic        clk = 1'b0;
  logic        rst, fs_read, fd_send;
  logic [3:0]  read_btype;
  logic [31:0] cache_cmd;
  logic        fd_read, fs_send, run;
  logic [3:0]  send_btype;
  logic [11:0] send_dlen, ram_addr_init;
  logic [7:0]  adc_rate, err_cnt;
  logic [15:0] chan_mask;

  com_cmd dut (
    .clk(clk), .rst(rst), .fs_read(fs_read), .read_btype(read_btype),
    .cache_cmd(cache_cmd), .fd_read(fd_read), .fs_send(fs_send),
    .send_btype(send_btype), .send_dlen(send_dlen), .ram_addr_init(ram_addr_init),
    .fd_send(fd_send), .adc_rate(adc_rate), .chan_mask(chan_mask), .run(run),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bt;
    logic [31:0] w;
    logic [7:0]  rate;
    logic [15:0] mask;
    logic        run;
    logic [7:0]  err;
    logic        rep;
    logic [3:0]  rbt;
  } vec_t;

  typedef struct {
    logic [3:0]  bt;
    logic [11:0] dlen;
    logic [11:0] addr;
  } rep_t;

  rep_t sb[$];
  vec_t vecs[15];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cfg(input logic [7:0] rate, input logic [15:0] mask,
                           input logic r, input logic [7:0] err);
    chk("adc_rate", 32'(adc_rate), 32'(rate));
    chk("chan_mask", 32'(chan_mask), 32'(mask));
    chk("run", 32'(run), 32'(r));
    chk("err_cnt", 32'(err_cnt), 32'(err));
  endtask

  task automatic drive_cmd(input logic [3:0] bt, input logic [31:0] w);
    read_btype = bt;
    cache_cmd  = w;
    fs_read    = 1'b1;
  endtask

  // Waits for fd_read from an already-counted start; returns total edges seen.
  task automatic wait_fd_read(input int start, output int lat);
    lat = start;
    while (!fd_read && lat < 30) begin
      tick;
      lat++;
    end
  endtask

  task automatic finish_reply(input int dly);
    rep_t e;
    int   c;
    logic held;
    e = '{bt: 4'h0, dlen: 12'h0, addr: 12'h0};
    c = 0;
    while (!fs_send && c < 20) begin
      tick;
      c++;
    end
    chk("fs_send_rise", 32'(fs_send), 32'd1);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("send_btype", 32'(send_btype), 32'(e.bt));
      chk("send_dlen", 32'(send_dlen), 32'(e.dlen));
      chk("ram_addr_init", 32'(ram_addr_init), 32'(e.addr));
    end
    held = 1'b1;
    repeat (dly) begin
      tick;
      if (!fs_send || send_btype !== e.bt || send_dlen !== e.dlen ||
          ram_addr_init !== e.addr)
        held = 1'b0;
    end
    chk("fs_send_held", 32'(held), 32'd1);
    fd_send = 1'b1;
    c = 0;
    do begin
      tick;
      c++;
    end while (fs_send && c < 20);
    chk("fs_send_fall", 32'(fs_send), 32'd0);
    fd_send = 1'b0;
    tick;
  endtask

  task automatic run_cmd(input logic [3:0] bt, input logic [31:0] w, input int dly,
                         input logic rep, input logic [3:0] rbt, output int lat);
    logic quiet;
    if (rep) sb.push_back('{bt: rbt, dlen: 12'd4, addr: 12'h000});
    drive_cmd(bt, w);
    wait_fd_read(0, lat);
    chk("fd_read_latency", 32'(lat), 32'd4);
    fs_read = 1'b0;
    tick;
    chk("fd_read_drop", 32'(fd_read), 32'd0);
    if (rep) begin
      finish_reply(dly);
    end else begin
      quiet = 1'b1;
      repeat (6) begin
        if (fs_send) quiet = 1'b0;
        tick;
      end
      chk("no_reply", 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    int   lat;
    int   exp_err;
    logic flag;

    vecs[0]  = '{4'h1, 32'hA1003293, 8'h32, 16'hFFFF, 1'b0, 8'd0, 1'b1, 4'h2};
    vecs[1]  = '{4'h1, 32'hA2BEEF00, 8'h32, 16'hFFFF, 1'b0, 8'd1, 1'b1, 4'h3};
    vecs[2]  = '{4'h5, 32'hA1005544, 8'h32, 16'hFFFF, 1'b0, 8'd1, 1'b0, 4'h0};
    vecs[3]  = '{4'h1, 32'hA200F052, 8'h32, 16'h00F0, 1'b0, 8'd1, 1'b1, 4'h2};
    vecs[4]  = '{4'h1, 32'hA30000A3, 8'h32, 16'h00F0, 1'b1, 8'd1, 1'b1, 4'h2};
    vecs[5]  = '{4'h1, 32'hA50000A5, 8'h0A, 16'hFFFF, 1'b0, 8'd1, 1'b1, 4'h2};
    vecs[6]  = '{4'h1, 32'hA1007FDE, 8'h7F, 16'hFFFF, 1'b0, 8'd1, 1'b1, 4'h2};
    vecs[7]  = '{4'h1, 32'hB10000B1, 8'h7F, 16'hFFFF, 1'b0, 8'd2, 1'b1, 4'h3};
    vecs[8]  = '{4'h1, 32'hA60000A6, 8'h7F, 16'hFFFF, 1'b0, 8'd3, 1'b1, 4'h3};
    vecs[9]  = '{4'h1, 32'hA00000A0, 8'h7F, 16'hFFFF, 1'b0, 8'd3, 1'b1, 4'h2};
    vecs[10] = '{4'h0, 32'hA50000A5, 8'h7F, 16'hFFFF, 1'b0, 8'd3, 1'b0, 4'h0};
    vecs[11] = '{4'h1, 32'hA20F0FA2, 8'h7F, 16'h0F0F, 1'b0, 8'd3, 1'b1, 4'h2};
    vecs[12] = '{4'h1, 32'hA30000A3, 8'h7F, 16'h0F0F, 1'b1, 8'd3, 1'b1, 4'h2};
    vecs[13] = '{4'h1, 32'hA40000A4, 8'h7F, 16'h0F0F, 1'b0, 8'd3, 1'b1, 4'h2};
    vecs[14] = '{4'h1, 32'hAF0000AF, 8'h7F, 16'h0F0F, 1'b0, 8'd4, 1'b1, 4'h3};

    rst = 1'b1; fs_read = 1'b0; fd_send = 1'b0; read_btype = '0; cache_cmd = '0;
    tick;
    chk("rst_fd_read", 32'(fd_read), 32'd0);
    chk("rst_fs_send", 32'(fs_send), 32'd0);
    chk("rst_send_btype", 32'(send_btype), 32'd0);
    chk("rst_send_dlen", 32'(send_dlen), 32'd0);
    check_cfg(8'd10, 16'hFFFF, 1'b0, 8'd0);
    tick;
    rst = 1'b0;
    tick;

    // Table: each command's config is sampled on the fd_read edge, where APPLY lands.
    foreach (vecs[i]) begin
      if (vecs[i].rep) sb.push_back('{bt: vecs[i].rbt, dlen: 12'd4, addr: 12'h000});
      drive_cmd(vecs[i].bt, vecs[i].w);
      wait_fd_read(0, lat);
      chk("vec_latency", 32'(lat), 32'd4);
      check_cfg(vecs[i].rate, vecs[i].mask, vecs[i].run, vecs[i].err);
      fs_read = 1'b0;
      tick;
      chk("vec_fd_read_drop", 32'(fd_read), 32'd0);
      if (vecs[i].rep) begin
        finish_reply(i % 3);
      end else begin
        flag = 1'b1;
        repeat (6) begin
          if (fs_send) flag = 1'b0;
          tick;
        end
        chk("vec_no_reply", 32'(flag), 32'd1);
      end
    end
    exp_err = 4;

    // fs_read drops one cycle after being seen: word already latched.
    sb.push_back('{bt: 4'h2, dlen: 12'd4, addr: 12'h000});
    drive_cmd(4'h1, 32'hA10055F4);
    tick;
    fs_read = 1'b0;
    wait_fd_read(1, lat);
    chk("early_fall_latency", 32'(lat), 32'd4);
    chk("early_fall_rate", 32'(adc_rate), 32'h55);
    tick;
    chk("early_fall_fd_read_1cyc", 32'(fd_read), 32'd0);
    finish_reply(0);

    // fd_send already high when REPLY is entered.
    sb.push_back('{bt: 4'h2, dlen: 12'd4, addr: 12'h000});
    drive_cmd(4'h1, 32'hA30000A3);
    wait_fd_read(0, lat);
    chk("pre_fd_latency", 32'(lat), 32'd4);
    fd_send = 1'b1;
    fs_read = 1'b0;
    tick;
    chk("pre_fd_fs_send_on", 32'(fs_send), 32'd1);
    if (sb.size() > 0) chk("pre_fd_btype", 32'(send_btype), 32'(sb.pop_front().bt));
    tick;
    chk("pre_fd_fs_send_1cyc", 32'(fs_send), 32'd0);
    chk("pre_fd_run", 32'(run), 32'd1);
    fd_send = 1'b0;
    tick;

    // New fs_read during REPLY must wait until IDLE, then be served.
    sb.push_back('{bt: 4'h2, dlen: 12'd4, addr: 12'h000});
    drive_cmd(4'h1, 32'hA00000A0);
    wait_fd_read(0, lat);
    fs_read = 1'b0;
    tick;
    chk("busy_fs_send", 32'(fs_send), 32'd1);
    if (sb.size() > 0) chk("busy_btype", 32'(send_btype), 32'(sb.pop_front().bt));
    drive_cmd(4'h1, 32'hA1003293);
    flag = 1'b1;
    repeat (4) begin
      tick;
      if (fd_read || !fs_send) flag = 1'b0;
    end
    chk("busy_fs_read_ignored", 32'(flag), 32'd1);
    chk("busy_rate_unchanged", 32'(adc_rate), 32'h55);
    fd_send = 1'b1;
    tick;
    fd_send = 1'b0;
    sb.push_back('{bt: 4'h2, dlen: 12'd4, addr: 12'h000});
    wait_fd_read(0, lat);
    chk("queued_latency", 32'(lat), 32'd5);
    chk("queued_rate", 32'(adc_rate), 32'h32);
    fs_read = 1'b0;
    tick;
    finish_reply(2);

    // 256 rejected commands with slow fd_send: err_cnt saturates.
    for (int unsigned k = 0; k < 256; k++) begin
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      run_cmd(4'h1, 32'hA2BEEF00, 5, 1'b1, 4'h3, lat);
      chk("sat_err_cnt", 32'(err_cnt), 32'(exp_err));
    end
    chk("sat_final", 32'(err_cnt), 32'hFF);
    chk("sat_mask_kept", 32'(chan_mask), 32'h0F0F);

    // Reset mid-REPLY abandons the handshake.
    run_cmd(4'h1, 32'hA30000A3, 0, 1'b1, 4'h2, lat);
    chk("pre_rst_run", 32'(run), 32'd1);
    drive_cmd(4'h1, 32'hA1003293);
    wait_fd_read(0, lat);
    fs_read = 1'b0;
    tick;
    chk("rst_in_reply", 32'(fs_send), 32'd1);
    rst = 1'b1;
    tick;
    chk("mid_rst_fs_send", 32'(fs_send), 32'd0);
    chk("mid_rst_fd_read", 32'(fd_read), 32'd0);
    chk("mid_rst_send_btype", 32'(send_btype), 32'd0);
    check_cfg(8'd10, 16'hFFFF, 1'b0, 8'd0);
    tick;
    rst = 1'b0;
    flag = 1'b1;
    repeat (6) begin
      tick;
      if (fs_send || fd_read) flag = 1'b0;
    end
    chk("post_rst_quiet", 32'(flag), 32'd1);
    run_cmd(4'h1, 32'hA1003293, 1, 1'b1, 4'h2, lat);
    check_cfg(8'h32, 16'hFFFF, 1'b0, 8'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/com_cmd.md
Name: com_cmd

Overview:
- Command sink directly downstream of the com receive path.
- Consumes each received packet announced on fs_read/read_btype/cache_cmd, validates and decodes the 32-bit command word, and updates a small set of acquisition config registers.
- Acknowledges the read with fd_read, then requests an ACK/NAK reply packet on the com send interface (fs_send/fd_send).
- Runs on the system clock domain, the same domain as the com control path.

Parameters:
- BTYPE_CMD, 4'h1, read_btype value carrying a command word.
- BTYPE_ACK, 4'h2, send_btype for a positive reply.
- BTYPE_NAK, 4'h3, send_btype for a negative reply.
- REPLY_DLEN, 12'd4, send_dlen for either reply.
- REPLY_ADDR, 12'h000, ram_addr_init for either reply.
- RATE_DEF, 8'd10, reset/default value of adc_rate.
- MASK_DEF, 16'hFFFF, reset/default value of chan_mask.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fs_read  in  1  packet-received strobe; level, held until fd_read is seen.
- read_btype  in  4  packet type, valid while fs_read=1.
- cache_cmd  in  32  command word, valid while fs_read=1.
- fd_read  out  1  read done; held high until fs_read falls.
- fs_send  out  1  reply request; held high until fd_send=1.
- send_btype  out  4  reply type.
- send_dlen  out  12  reply length.
- ram_addr_init  out  12  reply RAM start address.
- fd_send  in  1  reply done.
- adc_rate  out  8  config register.
- chan_mask  out  16  config register.
- run  out  1  acquisition enable.
- err_cnt  out  8  saturating count of rejected commands.

Behaviour:
Command word format:
- [31:28] sync, must be 4'hA.
- [27:24] opcode.
- [23:8] data.
- [7:0] checksum, must equal cache_cmd[31:24] ^ [23:16] ^ [15:8].

Opcodes:
- 0 NOP: no register change.
- 1 SET_RATE: adc_rate <= data[7:0].
- 2 SET_MASK: chan_mask <= data.
- 3 START: run <= 1.
- 4 STOP: run <= 0.
- 5 DEFAULTS: adc_rate <= RATE_DEF, chan_mask <= MASK_DEF, run <= 0.
- 6..15: invalid.

Reset:
- Synchronous; all outputs take reset values on the first clk edge with rst=1, from any state.
- Reset values: fd_read=0, fs_send=0, send_btype=0, send_dlen=0, ram_addr_init=0, adc_rate=RATE_DEF, chan_mask=MASK_DEF, run=0, err_cnt=0.
- FSM returns to IDLE.
- An in-flight handshake is abandoned: no fd_read and no reply is generated for it.

FSM (one state per cycle unless a wait is noted):
- IDLE: on fs_read=1 -> LATCH.
- LATCH: capture cache_cmd and read_btype into internal registers -> CHECK.
- CHECK: ok = (btype==BTYPE_CMD) & sync ok & checksum ok & opcode<=5 -> APPLY.
- APPLY:
  - ok: update the register selected by the opcode.
  - btype==BTYPE_CMD & !ok: err_cnt increments, saturating at 8'hFF.
  - btype!=BTYPE_CMD: no error and no reply.
  - -> ACK.
- ACK: fd_read=1; wait for fs_read=0, then fd_read=0.
  - btype==BTYPE_CMD -> REPLY.
  - otherwise -> IDLE.
- REPLY: fs_send=1, send_btype=ok?BTYPE_ACK:BTYPE_NAK, send_dlen=REPLY_DLEN, ram_addr_init=REPLY_ADDR; wait for fd_send=1 -> RDONE.
- RDONE: fs_send=0; wait for fd_send=0 -> IDLE.

Timing and boundary conditions:
- Latency: fs_read rise at edge N -> fd_read=1 at edge N+4; register update visible at edge N+4.
- send_btype, send_dlen and ram_addr_init are held stable for the whole of REPLY/RDONE.
- fs_read asserted during REPLY/RDONE is ignored until the FSM returns to IDLE. The command is not lost, because fs_read is level-held by the producer.
- fd_send=1 already high on entry to REPLY: exit on the next cycle, leaving fs_send high for exactly 1 cycle.
- fs_read falls before ACK: treated as normal. The word is already latched, and ACK sees fs_read=0 immediately.
- Config registers change only in APPLY or on reset.

Test Plan:
- Reset: assert rst for 2 cycles mid-REPLY -> fs_send=0, fd_read=0, adc_rate=10, chan_mask=FFFF, run=0, err_cnt=0, FSM in IDLE.
- Valid SET_RATE, word 32'hA1003297 (checksum A1^00^32=93; bench uses the correctly computed checksum 8'h93, word 32'hA1003293), btype 1 -> fd_read high 4 cycles after fs_read; adc_rate=8'h32; fs_send with send_btype=2, send_dlen=4, ram_addr_init=0.
- Bad checksum, word 32'hA2BEEF00 -> chan_mask unchanged; err_cnt=1; reply send_btype=3.
- Non-command btype 4'h5 with any word -> fd_read handshake completes; fs_send never asserts; no register changes; err_cnt unchanged.
- START, then DEFAULTS after a prior SET_MASK 16'h00F0 -> run=1 after the first command; after DEFAULTS run=0, chan_mask=FFFF; both replies ACK.
- 256 consecutive bad commands, with fd_send delayed 5 cycles on each -> err_cnt saturates at FF; every fs_send is held until fd_send; no fs_read is missed.
